modulo_transpor_seq: RTL and testbench

Parametrised, multi-cycle matrix transform unit for the arithmetic coprocessor. It accepts one flattened matrix of up to N×N signed elements through a valid/ready handshake and applies a runtime-selected operation on a runtime-selected active size. The operations are transpose, copy or negated transpose. It builds the result one output row per cycle and holds it until the consumer acknowledges. It sits between the coprocessor operand registers and the result bus, and replaces the fixed-size, single-cycle transpose stage.

---
 rtl/modulo_transpor_seq.sv | 127 ++++++++++++
 tb/tb_modulo_transpor_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/modulo_transpor_seq.sv
// modulo_transpor_seq: multi-cycle matrix transform unit (transpose, copy,
// negated transpose) over an N x N signed operand with a runtime active size.
// The result is built one output row per cycle and held until acknowledged.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds its payload stable while valid is high and
// ready is low, and the receiver never makes ready depend on a pending
// payload value. in_ready is a pure decode of state and rst_n; out_valid is
// held until out_ready is seen in DONE.
module modulo_transpor_seq #(
  parameter int N      = 5,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*N*DATA_W-1:0]     matrix_in,
  input  logic [2:0]                size,
  input  logic [1:0]                mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N*N*DATA_W-1:0]     matrix_out,
  output logic                      error,
  output logic                      busy,
  output logic [1:0]                dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] MODE_TRANSPOSE = 2'b00;
  localparam logic [1:0] MODE_COPY      = 2'b01;
  localparam logic [1:0] MODE_NEG_TRANS = 2'b10;
  localparam logic [1:0] MODE_RESERVED  = 2'b11;

  logic [1:0]              state;
  logic [2:0]              r;
  logic [2:0]              sz;
  logic [1:0]              md;
  logic [N*N*DATA_W-1:0]   in_reg;
  logic [N*N*DATA_W-1:0]   next_mat;
  logic [DATA_W-1:0]       e;
  logic                    req_bad;

  assign in_ready  = (state == IDLE) && rst_n;
  assign dbg_state = state;

  // Illegal request: zero size, size beyond N, or the reserved mode.
  assign req_bad = (size == 3'd0) || (int'(size) > N) || (mode == MODE_RESERVED);

  // Result matrix with output row r filled in for columns below the active size.
  always_comb begin
    next_mat = matrix_out;
    e        = '0;
    for (int c = 0; c < N; c++) begin
      e = '0;
      if (c < int'(sz)) begin
        case (md)
          MODE_COPY:      e = in_reg[(int'(r)*N + c)*DATA_W +: DATA_W];
          MODE_NEG_TRANS: e = -in_reg[(c*N + int'(r))*DATA_W +: DATA_W];
          default:        e = in_reg[(c*N + int'(r))*DATA_W +: DATA_W];
        endcase
        next_mat[(int'(r)*N + c)*DATA_W +: DATA_W] = e;
      end
    end
  end

  // Control FSM, operand latch and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      r          <= '0;
      sz         <= '0;
      md         <= MODE_TRANSPOSE;
      in_reg     <= '0;
      matrix_out <= '0;
      out_valid  <= 1'b0;
      error      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_reg     <= matrix_in;
            sz         <= size;
            md         <= mode;
            matrix_out <= '0;
            r          <= '0;
            busy       <= 1'b1;
            if (req_bad) begin
              error     <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              error     <= 1'b0;
              state     <= BUSY;
            end
          end
        end
        BUSY: begin
          matrix_out <= next_mat;
          if (int'(r) == int'(sz) - 1) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            r <= r + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_transpor_seq.sv
// Directed bench for modulo_transpor_seq with N=5, DATA_W=8.
module tb_modulo_transpor_seq;

  localparam int N  = 5;
  localparam int DW = 8;
  localparam int MW = N*N*DW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] matrix_in;
  logic [2:0]    size;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] matrix_out;
  logic          error;
  logic          busy;
  logic [1:0]    dbg_state;

  int tests;
  int fails;

  modulo_transpor_seq #(.N(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .matrix_in(matrix_in), .size(size), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .matrix_out(matrix_out), .error(error),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] el(input logic [MW-1:0] m, input int i, input int j);
    return m[(i*N + j)*DW +: DW];
  endfunction

  // Driver: present one request, scramble matrix_in after the accept edge,
  // and count edges (accept edge included) until out_valid is seen.
  task automatic send(input logic [MW-1:0] m, input logic [2:0] s,
                      input logic [1:0] md, output int lat);
    matrix_in = m; size = s; mode = md; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    matrix_in = ~m;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Driver: one-cycle result acknowledge.
  task automatic ack;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (matrix_out !== '0) begin fails++; $display("FAIL reset_mat got=%h exp=0", matrix_out); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error got=%b exp=0", error); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    rst_n = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_transpose;
    logic [MW-1:0] m;
    int lat;
    int nz;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[(i*N + j)*DW +: DW] = 8'(10*i + j);
    send(m, 3'd3, 2'b00, lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL tr_latency got=%0d exp=4", lat); end
    tests++; if (el(matrix_out, 0, 1) !== 8'd10) begin fails++; $display("FAIL tr_out01 got=%0d exp=10", el(matrix_out, 0, 1)); end
    tests++; if (el(matrix_out, 2, 0) !== 8'd2) begin fails++; $display("FAIL tr_out20 got=%0d exp=2", el(matrix_out, 2, 0)); end
    tests++; if (el(matrix_out, 1, 2) !== 8'd21) begin fails++; $display("FAIL tr_out12 got=%0d exp=21", el(matrix_out, 1, 2)); end
    tests++; if (el(matrix_out, 2, 2) !== 8'd22) begin fails++; $display("FAIL tr_out22 got=%0d exp=22", el(matrix_out, 2, 2)); end
    nz = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if ((i >= 3 || j >= 3) && el(matrix_out, i, j) !== 8'd0) nz++;
    tests++; if (nz !== 0) begin fails++; $display("FAIL tr_outside_zero got=%0d nonzero exp=0", nz); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL tr_error got=%b exp=0", error); end
    ack();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL tr_ack got=ov%b ir%b exp=ov0 ir1", out_valid, in_ready); end
  endtask

  task automatic test_neg_transpose;
    logic [MW-1:0] m;
    int lat;
    m = '0;
    m[(0*N + 0)*DW +: DW] = 8'h80;
    m[(0*N + 1)*DW +: DW] = 8'h01;
    m[(1*N + 0)*DW +: DW] = 8'h7F;
    m[(1*N + 1)*DW +: DW] = 8'h00;
    m[(2*N + 2)*DW +: DW] = 8'h33;
    send(m, 3'd2, 2'b10, lat);
    tests++; if (lat !== 3) begin fails++; $display("FAIL neg_latency got=%0d exp=3", lat); end
    tests++; if (el(matrix_out, 0, 0) !== 8'h80) begin fails++; $display("FAIL neg_out00 got=%h exp=80", el(matrix_out, 0, 0)); end
    tests++; if (el(matrix_out, 0, 1) !== 8'h81) begin fails++; $display("FAIL neg_out01 got=%h exp=81", el(matrix_out, 0, 1)); end
    tests++; if (el(matrix_out, 1, 0) !== 8'hFF) begin fails++; $display("FAIL neg_out10 got=%h exp=ff", el(matrix_out, 1, 0)); end
    tests++; if (el(matrix_out, 1, 1) !== 8'h00) begin fails++; $display("FAIL neg_out11 got=%h exp=00", el(matrix_out, 1, 1)); end
    tests++; if (el(matrix_out, 2, 2) !== 8'h00) begin fails++; $display("FAIL neg_out22 got=%h exp=00", el(matrix_out, 2, 2)); end
    ack();
  endtask

  task automatic test_copy_backpressure;
    logic [MW-1:0] m;
    int lat;
    for (int k = 0; k < N*N; k++) m[k*DW +: DW] = 8'($urandom_range(0, 255));
    send(m, 3'd5, 2'b01, lat);
    tests++; if (lat !== 6) begin fails++; $display("FAIL copy_latency got=%0d exp=6", lat); end
    tests++; if (matrix_out !== m) begin fails++; $display("FAIL copy_mat got=%h exp=%h", matrix_out, m); end
    in_valid = 1'b1; matrix_in = ~m; size = 3'd2; mode = 2'b00;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || matrix_out !== m) begin
        fails++;
        $display("FAIL bp_hold cycle=%0d got=ov%b ir%b mat_ok%b exp=ov1 ir0 mat_ok1", k, out_valid, in_ready, matrix_out === m);
      end
    end
    in_valid = 1'b0;
    ack();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_release got=ov%b ir%b exp=ov0 ir1", out_valid, in_ready); end
    tests++; if (matrix_out !== m) begin fails++; $display("FAIL bp_mat_kept got=%h exp=%h", matrix_out, m); end
    repeat (3) @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL bp_ignored got=ov%b busy%b exp=ov0 busy0", out_valid, busy); end
  endtask

  task automatic test_errors;
    logic [2:0] sz_t [3];
    logic [1:0] md_t [3];
    logic [MW-1:0] m;
    int lat;
    sz_t[0] = 3'd0; md_t[0] = 2'b00;
    sz_t[1] = 3'd6; md_t[1] = 2'b01;
    sz_t[2] = 3'd3; md_t[2] = 2'b11;
    m = {MW{1'b1}};
    for (int t = 0; t < 3; t++) begin
      send(m, sz_t[t], md_t[t], lat);
      tests++; if (lat !== 1) begin fails++; $display("FAIL err%0d_latency got=%0d exp=1", t, lat); end
      tests++; if (error !== 1'b1) begin fails++; $display("FAIL err%0d_flag got=%b exp=1", t, error); end
      tests++; if (matrix_out !== '0) begin fails++; $display("FAIL err%0d_mat got=%h exp=0", t, matrix_out); end
      ack();
    end
  endtask

  task automatic test_reset_busy;
    logic [MW-1:0] m;
    int seen;
    m = {MW{1'b1}};
    matrix_in = m; size = 3'd5; mode = 2'b01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    tests++; if (busy !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL rb_mid got=busy%b ov%b exp=busy1 ov0", busy, out_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (matrix_out !== '0 || out_valid !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rb_cleared got=ov%b err%b busy%b mat_zero%b exp=0 0 0 1", out_valid, error, busy, matrix_out === '0);
    end
    rst_n = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rb_in_ready got=%b exp=1", in_ready); end
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL rb_no_result got=%0d valid cycles exp=0", seen); end
  endtask

  initial begin
    tests = 0; fails = 0;
    in_valid = 1'b0; out_ready = 1'b0; matrix_in = '0; size = 3'd0; mode = 2'b00;
    rst_n = 1'b0;
    test_reset();
    @(posedge clk); #1;
    test_transpose();
    test_neg_transpose();
    test_copy_backpressure();
    test_errors();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
